// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch sequencer with redirect arbitration and a one-entry skid buffer
module if_fetch_ctrl #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic        pc_en,
  output logic [31:0] next_pc,
  input  logic        stall_if,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic        branch_valid,
  input  logic [31:0] branch_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  typedef enum logic [1:0] {BOOT, FETCH, FLUSH, HOLD} state_e;
  state_e state_q, state_d;
  logic        redir, fetching, ack, deliver;
  logic [31:0] target, pend_q, skid_inst_q, skid_pc_q;
  logic        inst_valid_q;
  logic [31:0] inst_q, inst_pc_q;
  assign redir    = trap_valid | branch_valid;
  assign target   = {(trap_valid ? trap_pc[31:2] : branch_pc[31:2]), 2'b00};
  assign fetching = (state_q == FETCH) || (state_q == FLUSH);
  assign ack      = fetching & imem_ack;
  assign deliver  = !redir && !stall_if && ((state_q == HOLD) || (state_q == FETCH && ack));
  always_ff @(posedge clk) begin
    state_q <= reset ? BOOT : state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = (redir && !ack) ? FLUSH : (ack && !redir && stall_if) ? HOLD : FETCH;
      FLUSH:   state_d = ack ? FETCH : FLUSH;
      HOLD:    state_d = (redir || !stall_if) ? FETCH : HOLD;
      default: state_d = BOOT;
    endcase
  end
  // In FLUSH the old request completes before the PC jumps to the pending target
  always_comb begin
    imem_req  = fetching;
    imem_addr = current_pc;
    pc_en     = (state_q == HOLD) ? redir : ack;
    next_pc   = redir ? target : (state_q == FLUSH) ? pend_q : current_pc + PC_STEP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= '0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0000_0013;
      inst_pc_q    <= '0;
    end else begin
      if (fetching && redir && !ack) pend_q <= target;
      if (state_q == FETCH && ack && !redir && stall_if) begin
        skid_inst_q <= imem_rdata;
        skid_pc_q   <= current_pc;
      end
      if (redir || !stall_if) inst_valid_q <= deliver;
      if (deliver) begin
        inst_q    <= (state_q == HOLD) ? skid_inst_q : imem_rdata;
        inst_pc_q <= (state_q == HOLD) ? skid_pc_q : current_pc;
      end
    end
  end
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed bench with a transaction-level fetch model checked every cycle
module tb_if_fetch_ctrl;
  localparam logic [31:0] K = 32'h5A5A_0000;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] current_pc = '0, next_pc, trap_pc = '0, branch_pc = '0, imem_addr, imem_rdata = '0, inst, inst_pc;
  logic        pc_en, stall_if = 1'b0, trap_valid = 1'b0, branch_valid = 1'b0, imem_req, imem_ack = 1'b0, inst_valid;
  logic [31:0] pc_rst = '0;
  int checks = 0, failures = 0;
  int deliv[logic [31:0]];
  bit mv = 0, m_started, m_flush, m_held, m_v;
  logic [31:0] m_tgt, m_hi, m_hp, m_i, m_p;
  logic [3:0] tbl [20] = '{4'b0001, 4'b0001, 4'b1001, 4'b1000, 4'b0000, 4'b1010, 4'b1000, 4'b0000, 4'b0011, 4'b0000,
                           4'b0001, 4'b0100, 4'b0010, 4'b1001, 4'b1001, 4'b0101, 4'b0001, 4'b1000, 4'b0001, 4'b0000};
  if_fetch_ctrl dut (
    .clk(clk), .reset(reset), .current_pc(current_pc), .pc_en(pc_en), .next_pc(next_pc),
    .stall_if(stall_if), .trap_valid(trap_valid), .trap_pc(trap_pc), .branch_valid(branch_valid),
    .branch_pc(branch_pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset) current_pc <= pc_rst;
    else if (pc_en) current_pc <= next_pc;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  // One cycle: drive inputs, compare against the model, then advance the model across the next edge
  task automatic step(input bit rst, input bit st, input bit tv, input logic [31:0] tp,
                      input bit bv, input logic [31:0] bp, input bit ak);
    bit ereq, redir, ackd, epc;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    reset = rst; stall_if = st; trap_valid = tv; trap_pc = tp;
    branch_valid = bv; branch_pc = bp; imem_ack = ak; imem_rdata = current_pc ^ K;
    @(negedge clk);
    redir = tv || bv;
    tgt   = (tv ? tp : bp) & 32'hFFFF_FFFC;
    ereq  = m_started && !m_held;
    ackd  = ereq && ak;
    epc   = m_held ? redir : ackd;
    if (mv) begin
      chk1("imem_req", imem_req, ereq);
      chk1("pc_en", pc_en, epc);
      if (epc) chk("next_pc", next_pc, redir ? tgt : m_flush ? m_tgt : current_pc + 32'd4);
      if (ereq) chk("imem_addr", imem_addr, current_pc);
      chk1("inst_valid", inst_valid, m_v);
      chk("inst", inst, m_i);
      chk("inst_pc", inst_pc, m_p);
      if (inst_valid && !st) deliv[inst_pc] = deliv.exists(inst_pc) ? deliv[inst_pc] + 1 : 1;
    end
    if (rst) begin
      mv = 1; m_started = 0; m_flush = 0; m_held = 0; m_v = 0;
      m_tgt = '0; m_hi = '0; m_hp = '0; m_i = 32'h13; m_p = '0;
    end else begin
      if (redir) m_v = 0;
      else if (!st) begin
        if (m_held) begin m_v = 1; m_i = m_hi; m_p = m_hp; end
        else if (ackd && !m_flush) begin m_v = 1; m_i = current_pc ^ K; m_p = current_pc; end
        else m_v = 0;
      end
      if (m_held) m_held = !redir && st;
      else if (ackd && !m_flush && !redir && st) begin m_held = 1; m_hi = current_pc ^ K; m_hp = current_pc; end
      if (ereq && redir && !ackd) begin m_flush = 1; m_tgt = tgt; end
      else if (ackd) m_flush = 0;
      m_started = 1;
    end
  endtask
  task automatic run(input bit st, input bit ak);
    step(0, st, 0, '0, 0, '0, ak);
  endtask
  task automatic rst_seq(input logic [31:0] a);
    pc_rst = a;
    step(1, 0, 0, '0, 0, '0, 0);
    step(1, 0, 0, '0, 0, '0, 0);
    deliv.delete();
  endtask
  initial begin
    rst_seq(32'hFFFF_F000);
    run(0, 1);
    chk1("s1_boot_req", imem_req, 1'b0);
    chk1("s1_boot_valid", inst_valid, 1'b0);
    chk("s1_boot_inst", inst, 32'h0000_0013);
    chk("s1_boot_pc", inst_pc, 32'h0);
    run(0, 1);
    chk1("s1_c2_req", imem_req, 1'b1);
    chk("s1_c2_addr", imem_addr, 32'hFFFF_F000);
    run(0, 1);
    chk("s1_c3_addr", imem_addr, 32'hFFFF_F004);
    chk1("s1_c3_valid", inst_valid, 1'b1);
    chk("s1_c3_inst_pc", inst_pc, 32'hFFFF_F000);
    chk("s1_c3_inst", inst, 32'hA5A5_F000);
    run(0, 1);
    chk("s1_c4_addr", imem_addr, 32'hFFFF_F008);
    chk("s1_c4_inst_pc", inst_pc, 32'hFFFF_F004);
    rst_seq(32'h0000_00FC);
    run(0, 0);
    run(0, 1);
    run(1, 1);
    chk("s2_ack_addr", imem_addr, 32'h100);
    chk("s2_c3_inst_pc", inst_pc, 32'hFC);
    run(1, 0);
    chk1("s2_hold_req_a", imem_req, 1'b0);
    run(1, 0);
    chk1("s2_hold_req_b", imem_req, 1'b0);
    run(0, 0);
    chk1("s2_drain_req", imem_req, 1'b0);
    chk("s2_drain_pc", inst_pc, 32'hFC);
    run(0, 0);
    chk("s2_next_addr", imem_addr, 32'h104);
    chk("s2_buf_pc", inst_pc, 32'h100);
    run(0, 0);
    chk("s2_once_100", deliv.exists(32'h100) ? deliv[32'h100] : 0, 32'd1);
    chk("s2_once_fc", deliv.exists(32'hFC) ? deliv[32'hFC] : 0, 32'd1);
    rst_seq(32'h40);
    run(0, 0);
    step(0, 0, 0, '0, 1, 32'h2002, 0);
    chk1("s3_redir_pc_en", pc_en, 1'b0);
    run(0, 0);
    chk("s3_wait_addr", imem_addr, 32'h40);
    chk1("s3_wait_valid", inst_valid, 1'b0);
    run(0, 1);
    chk("s3_ack_next", next_pc, 32'h2000);
    run(0, 1);
    chk("s3_tgt_addr", imem_addr, 32'h2000);
    chk1("s3_tgt_valid", inst_valid, 1'b0);
    run(0, 0);
    chk("s3_tgt_inst_pc", inst_pc, 32'h2000);
    chk("s3_discarded", deliv.exists(32'h40), 32'd0);
    rst_seq(32'h40);
    run(0, 0);
    step(0, 0, 1, 32'h80, 1, 32'h400, 1);
    chk("s4_prio_next", next_pc, 32'h80);
    step(0, 0, 1, 32'h80, 0, '0, 0);
    chk("s4_trap_addr", imem_addr, 32'h80);
    step(0, 0, 0, '0, 1, 32'h500, 0);
    run(0, 1);
    chk("s4_latest_next", next_pc, 32'h500);
    run(0, 0);
    chk("s4_latest_addr", imem_addr, 32'h500);
    rst_seq(32'hFFFF_FFFC);
    run(0, 0);
    run(0, 1);
    chk("s5_wrap_next", next_pc, 32'h0);
    run(0, 0);
    chk("s5_wrap_addr", imem_addr, 32'h0);
    chk("s5_wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    rst_seq(32'h200);
    run(0, 0);
    run(0, 1);
    step(1, 0, 0, '0, 0, '0, 0);
    chk1("s6_pre_req", imem_req, 1'b1);
    run(0, 0);
    chk1("s6_post_req", imem_req, 1'b0);
    chk1("s6_post_valid", inst_valid, 1'b0);
    chk1("s6_post_pc_en", pc_en, 1'b0);
    run(0, 0);
    chk("s6_refetch_addr", imem_addr, 32'h200);
    rst_seq(32'h1000);
    for (int i = 0; i < 20; i++)
      step(0, tbl[i][3], tbl[i][2], 32'h3000 + i * 8, tbl[i][1], 32'h5001 + i * 8, tbl[i][0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer for the IF stage. It drives the enable and next-address inputs of the external program-counter register and runs a single-outstanding request/acknowledge handshake with instruction memory (boot ROM or IMEM). It also arbitrates trap and branch redirects, and holds a fetched instruction in a one-entry skid buffer while decode is stalled. It sits between the PC register, the instruction bus and the IF/ID boundary.

## Interface
- PC_STEP, default 4: byte increment of sequential fetch.
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- current_pc  in  32  present value of the PC register.
- pc_en  out  1  PC register load enable.
- next_pc  out  32  value the PC register loads when pc_en=1.
- stall_if  in  1  decode cannot accept an instruction this cycle.
- trap_valid / trap_pc  in  1 / 32  trap/exception redirect request and target.
- branch_valid / branch_pc  in  1 / 32  taken branch/jump redirect request and target.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ack  in  1  request complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- inst_valid / inst / inst_pc  out  1 / 32 / 32  registered IF/ID outputs.

## Operation
- The redirect target is trap_pc when trap_valid=1, otherwise branch_pc. Trap has priority in the same cycle. Target bits [1:0] are forced to 00.
- next_pc = current_pc + PC_STEP in modulo 2^32 arithmetic (0xFFFF_FFFC → 0x0000_0000) unless a redirect target is selected.
- Handshake: imem_addr = current_pc whenever imem_req=1. imem_ack is ignored when imem_req=0. An ack may arrive in the first request cycle (zero wait).
- BOOT: entered on reset; imem_req=0, pc_en=0. Next state is always FETCH.
- FETCH: imem_req=1.
  - Redirect with ack: discard rdata, pc_en=1, next_pc=target, stay in FETCH.
  - Redirect without ack: latch the target into the pending register, pc_en=0, go to FLUSH.
  - Ack, no redirect, stall_if=0: load the output registers with rdata and current_pc, pc_en=1 (sequential), stay in FETCH.
  - Ack, no redirect, stall_if=1: load the skid buffer, pc_en=1 (sequential), go to HOLD.
  - No ack: pc_en=0.
- FLUSH: imem_req=1 at the unchanged old address.
  - A new redirect overwrites the pending target; the latest redirect wins.
  - On ack: discard rdata, pc_en=1, next_pc = pending target (or a redirect arriving in the same cycle), go to FETCH.
- HOLD: imem_req=0.
  - Redirect: drop the buffer, pc_en=1, next_pc=target, go to FETCH.
  - Else if stall_if=0: move the buffer into the output registers, go to FETCH.
- Output registers:
  - Any redirect clears inst_valid at the next edge, even when stall_if=1.
  - Otherwise, with stall_if=1, inst_valid, inst and inst_pc hold their values.
  - Otherwise, with stall_if=0 and nothing delivered, inst_valid goes to 0 and inst/inst_pc hold.
- Reset mid-transaction: the FSM returns to BOOT and the outstanding request is abandoned. The bus must tolerate imem_req dropping before ack.

## Timing
- Reset values: state=BOOT, imem_req=0, pc_en=0, inst_valid=0, inst=0x0000_0013 (NOP), inst_pc=0, skid buffer empty, pending target=0.
- imem_addr and next_pc are combinational from current_pc and state.
- The first request is issued in the 2nd cycle after reset deassertion, at the PC register reset address.
- Ack in cycle N:
  - inst_valid=1 in N+1.
  - The PC advances at the end of N.
  - The next request (at +4) is issued in N+1.
  - Zero-wait throughput is therefore 1 instruction/cycle.
- Redirect in cycle N:
  - inst_valid=0 in N+1.
  - With ack in N, the first request to the target is in N+1.
  - Without ack in N, the first request to the target is in the cycle after the old ack.
- Exactly one instruction is delivered per non-discarded ack; none is lost or duplicated across HOLD.

## Test plan
- Reset, zero-wait ack, PC reset 0xFFFF_F000: imem_addr sequence F000, F004, F008 on consecutive cycles; inst_valid=1 from cycle 3 with inst_pc matching.
- Ack at 0x100, stall_if=1 for 3 cycles, then 0: inst(0x100) is delivered once, after the output register drains; no request is issued during HOLD; the next fetch is at 0x104.
- branch_valid (target 0x2002) in a wait-state cycle with 2-cycle ack latency: imem_addr stays at the old address until ack; that data is discarded; the next request is at 0x2000; inst_valid=0 in between.
- trap_valid (0x80) and branch_valid (0x400) in the same cycle: the next fetch is at 0x80. In FLUSH, a later branch to 0x500 overrides a pending trap to 0x80: the next fetch is at 0x500.
- current_pc=0xFFFF_FFFC, ack: next_pc=0x0000_0000.
- Reset asserted while imem_req=1 and no ack: next cycle imem_req=0, inst_valid=0, state=BOOT.
